// File: rtl/seq_padlock.sv
// Sequential-code padlock: one press per digit, inactivity timeout, optional
// failed-attempt lockout enabled by defining PADLOCK_LOCKOUT_EN.
module seq_padlock #(
  parameter int NUM_BUTTONS    = 10,
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] CODE = 16'h2049,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 4096,
  localparam int FW = $clog2(MAX_FAILS + 1),
  localparam int IW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] but,
  input  logic                   open,
  output logic                   lock,
  output logic                   armed,
  output logic                   lockout,
  output logic                   bad_code,
  output logic [FW-1:0]          fail_count,
  output logic [1:0]             dbg_state,
  output logic [IW-1:0]          dbg_idx
);

  localparam logic [1:0] S_ENTER   = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_OPEN    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  if (NUM_BUTTONS > 2**DIGIT_W || CODE_LEN < 1 || MAX_FAILS < 1 ||
      TIMEOUT_CYCLES < 1 || LOCKOUT_CYCLES < 1) begin : g_bad_params
    $error("seq_padlock: invalid parameter set");
  end

  logic [1:0]             state;
  logic [IW-1:0]          idx;
  logic                   err;
  logic [TW-1:0]          idle_cnt;
  logic [NUM_BUTTONS-1:0] but_s, but_p;
  logic                   press_r;
  logic [DIGIT_W-1:0]     dig_r;
  logic                   dig_ok_r;

  logic                   hold;
  logic                   onehot;
  logic [DIGIT_W-1:0]     dig;
  logic                   press_c;
  logic [DIGIT_W-1:0]     exp_dig;
  logic                   match;
  logic                   last;
  logic                   idle_run;
  logic                   timeout;
  logic                   bad_ev;
  logic                   to_lockout;
  logic                   lock_exit;
  logic                   open_exit;

  // Digit decode from the synchronised buttons; multi-button values never match.
  always_comb begin
    onehot = (but_s != '0) && ((but_s & (but_s - NUM_BUTTONS'(1))) == '0);
    dig    = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (but_s[i]) dig = DIGIT_W'(i);
    end
  end

  assign press_c  = (but_s != '0) && (but_p == '0) && !hold;
  assign exp_dig  = CODE[idx*DIGIT_W +: DIGIT_W];
  assign match    = dig_ok_r && (dig_r == exp_dig);
  assign last     = (idx == IW'(CODE_LEN - 1));
  assign idle_run = ((state == S_ENTER) && (idx != '0)) || (state == S_ARMED);
  assign timeout  = idle_run && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign bad_ev   = (state == S_ENTER) && press_r && last && (err || !match);
  assign open_exit = (state == S_OPEN) && !open;

  // All-ones reset of the input stage hides buttons held through reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      but_s    <= '1;
      but_p    <= '1;
      press_r  <= 1'b0;
      dig_r    <= '0;
      dig_ok_r <= 1'b0;
    end else begin
      but_s    <= but;
      but_p    <= but_s;
      press_r  <= press_c;
      dig_r    <= dig;
      dig_ok_r <= onehot;
    end
  end

`ifdef PADLOCK_LOCKOUT_EN
  logic [LW-1:0] lock_cnt;
  logic          hold_r;

  assign hold       = hold_r;
  assign lockout    = (state == S_LOCKOUT);
  assign to_lockout = bad_ev && (fail_count >= FW'(MAX_FAILS - 1));
  assign lock_exit  = (state == S_LOCKOUT) && (lock_cnt == LW'(LOCKOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt   <= '0;
      fail_count <= '0;
      hold_r     <= 1'b0;
    end else begin
      if (state == S_LOCKOUT) lock_cnt <= lock_exit ? '0 : lock_cnt + 1'b1;
      else                    lock_cnt <= '0;
      if (lock_exit || open_exit) fail_count <= '0;
      else if (bad_ev)            fail_count <= to_lockout ? FW'(MAX_FAILS) : fail_count + 1'b1;
      // A button still down when lockout ends must be released before it counts.
      if (state == S_LOCKOUT)  hold_r <= 1'b1;
      else if (but_s == '0)    hold_r <= 1'b0;
    end
  end
`else
  assign hold       = 1'b0;
  assign lockout    = 1'b0;
  assign to_lockout = 1'b0;
  assign lock_exit  = 1'b0;
  assign fail_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_ENTER;
      idx      <= '0;
      err      <= 1'b0;
      idle_cnt <= '0;
      lock     <= 1'b1;
      bad_code <= 1'b0;
    end else begin
      bad_code <= 1'b0;
      idle_cnt <= (idle_run && !press_r) ? idle_cnt + 1'b1 : '0;
      case (state)
        S_ENTER: begin
          if (press_r) begin
            idle_cnt <= '0;
            if (last) begin
              idx <= '0;
              err <= 1'b0;
              if (!bad_ev)         state <= S_ARMED;
              else begin
                bad_code <= 1'b1;
                if (to_lockout)    state <= S_LOCKOUT;
              end
            end else begin
              idx <= idx + 1'b1;
              err <= err | !match;
            end
          end else if (timeout) begin
            idx      <= '0;
            err      <= 1'b0;
            idle_cnt <= '0;
          end
        end
        S_ARMED: begin
          if (press_r || timeout) begin
            state    <= S_ENTER;
            idx      <= '0;
            err      <= 1'b0;
            idle_cnt <= '0;
          end else if (open) begin
            state    <= S_OPEN;
            lock     <= 1'b0;
            idle_cnt <= '0;
          end
        end
        S_OPEN: begin
          if (open_exit) begin
            state <= S_ENTER;
            lock  <= 1'b1;
          end
        end
        S_LOCKOUT: begin
          if (lock_exit) begin
            state <= S_ENTER;
            idx   <= '0;
            err   <= 1'b0;
          end
        end
        default: state <= S_ENTER;
      endcase
    end
  end

  assign armed     = (state == S_ARMED);
  assign dbg_state = state;
  assign dbg_idx   = idx;

endmodule

// File: tb/tb_seq_padlock.sv
// Directed bench for seq_padlock: outcome scoreboard for bad_code/armed events
// plus immediate-assertion checks along a linear stimulus sequence.
module tb_seq_padlock;
  localparam int NB = 10;
  localparam int FW = 2;
  localparam int IW = 2;
  localparam logic [1:0] EV_BAD = 2'd1;
  localparam logic [1:0] EV_ARM = 2'd2;
`ifdef PADLOCK_LOCKOUT_EN
  localparam int LK = 1;
`else
  localparam int LK = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] but;
  logic          open;
  logic          lock, armed, lockout, bad_code;
  logic [FW-1:0] fail_count;
  logic [1:0]    dbg_state;
  logic [IW-1:0] dbg_idx;

  int n_assert = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];
  logic armed_d = 1'b0;
  int lock_low_total = 0;
  int lockout_total  = 0;
  int snap;

  seq_padlock #(.TIMEOUT_CYCLES(20), .LOCKOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .but(but), .open(open), .lock(lock),
    .armed(armed), .lockout(lockout), .bad_code(bad_code),
    .fail_count(fail_count), .dbg_state(dbg_state), .dbg_idx(dbg_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_event(input logic [1:0] ev);
    logic [1:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL event: observed %0d, expected none", ev);
    end else begin
      e = exp_q.pop_front();
      assert (ev === e) else begin
        n_fail++;
        $error("FAIL event: observed %0d, expected %0d", ev, e);
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bad_code) chk_event(EV_BAD);
      if (armed && !armed_d) chk_event(EV_ARM);
      if (!lock) lock_low_total <= lock_low_total + 1;
      if (lockout) lockout_total <= lockout_total + 1;
    end
    armed_d <= armed;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_mask(input logic [NB-1:0] m);
    but = m;
    tick();
    but = '0;
    tick();
    tick();
  endtask

  task automatic press(input int d);
    press_mask(NB'(1) << d);
  endtask

  task automatic enter(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
  endtask

  initial begin
    reset = 1'b1; but = '0; open = 1'b0;
    tick(); tick();
    chk("rst_lock", lock, 1);
    chk("rst_armed", armed, 0);
    chk("rst_lockout", lockout, 0);
    chk("rst_bad", bad_code, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_idx", dbg_idx, 0);
    reset = 1'b0;
    tick();

    // Correct code then a 5-cycle open
    exp_q.push_back(EV_ARM);
    enter(9, 4, 0, 2);
    chk("ok_armed", armed, 1);
    chk("ok_lock_pre", lock, 1);
    snap = lock_low_total;
    open = 1'b1;
    repeat (5) tick();
    open = 1'b0;
    tick(); tick();
    chk("ok_lock_cycles", lock_low_total - snap, 5);
    chk("ok_lock_post", lock, 1);
    chk("ok_state", dbg_state, 0);

    // Wrong digit, then the correct code arms
    exp_q.push_back(EV_BAD);
    enter(9, 4, 1, 2);
    chk("bad_fail", fail_count, LK);
    chk("bad_armed", armed, 0);
    chk("bad_lock", lock, 1);
    exp_q.push_back(EV_ARM);
    enter(9, 4, 0, 2);
    chk("bad_rearm", armed, 1);
    open = 1'b1;
    tick(); tick();
    open = 1'b0;
    tick();
    chk("bad_fail_clr", fail_count, 0);
    chk("bad_state", dbg_state, 0);

`ifdef PADLOCK_LOCKOUT_EN
    // Three bad codes lock the keypad out for 16 cycles
    snap = lockout_total;
    exp_q.push_back(EV_BAD);
    enter(1, 1, 1, 1);
    exp_q.push_back(EV_BAD);
    enter(1, 1, 1, 1);
    chk("lo_fail2", fail_count, 2);
    chk("lo_not_yet", lockout, 0);
    exp_q.push_back(EV_BAD);
    enter(1, 1, 1, 1);
    chk("lo_active", lockout, 1);
    chk("lo_fail3", fail_count, 3);
    enter(9, 4, 0, 2);
    chk("lo_ignored", armed, 0);
    repeat (10) tick();
    chk("lo_done", lockout, 0);
    chk("lo_cycles", lockout_total - snap, 16);
    chk("lo_fail_clr", fail_count, 0);
    chk("lo_state", dbg_state, 0);
    chk("lo_idx", dbg_idx, 0);
    exp_q.push_back(EV_ARM);
    enter(9, 4, 0, 2);
    chk("lo_arm", armed, 1);
    open = 1'b1;
    tick();
    open = 1'b0;
    tick(); tick();
`endif

    // Two buttons at once form an invalid digit
    exp_q.push_back(EV_BAD);
    press_mask((NB'(1) << 9) | (NB'(1) << 4));
    press(4); press(0); press(2);
    chk("multi_armed", armed, 0);
    chk("multi_fail", fail_count, LK);
    chk("multi_lockout", lockout, 0);

    // Partial entry times out; armed state cancelled by a press
    press(9); press(4);
    chk("to_idx2", dbg_idx, 2);
    repeat (10) tick();
    chk("to_idx_hold", dbg_idx, 2);
    repeat (15) tick();
    chk("to_idx0", dbg_idx, 0);
    chk("to_fail", fail_count, LK);
    chk("to_state", dbg_state, 0);
    exp_q.push_back(EV_ARM);
    enter(9, 4, 0, 2);
    chk("to_armed", armed, 1);
    press(5);
    chk("cancel_state", dbg_state, 0);
    chk("cancel_idx", dbg_idx, 0);
    open = 1'b1;
    repeat (3) tick();
    chk("cancel_lock", lock, 1);
    chk("cancel_state2", dbg_state, 0);
    open = 1'b0;
    tick();

    // Reset while open, with a button held through reset
    exp_q.push_back(EV_ARM);
    enter(9, 4, 0, 2);
    open = 1'b1;
    tick(); tick();
    chk("rso_lock_open", lock, 0);
    but = NB'(1) << 3;
    reset = 1'b1;
    open = 1'b0;
    tick();
    chk("rso_lock", lock, 1);
    chk("rso_armed", armed, 0);
    chk("rso_state", dbg_state, 0);
    chk("rso_fail", fail_count, 0);
    reset = 1'b0;
    repeat (4) tick();
    chk("rso_held_idx", dbg_idx, 0);
    but = '0;
    tick(); tick();
    press(9);
    chk("rso_press_idx", dbg_idx, 1);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
